weight_buffer_writer: RTL and testbench

- Writer side of the packed weight buffer: accepts a stream of 7-bit weights over a valid/ready handshake.
- Packs 4 weights per word, MSB-first, and writes 256 × 28-bit words into the weight RAM.
- This produces exactly the layout the weight-loading path reads back: word N holds weights 4N..4N+3, with the first weight in [27:21].
- Sits between the host/SPI weight-download path and the weight buffer RAM write port.

---
 rtl/weight_pkg.sv | 21 ++
 rtl/weight_buffer_writer_if.sv | 29 ++
 rtl/weight_packer.sv | 36 +++
 rtl/weight_buffer_writer.sv | 133 +++++++++++++
 tb/tb_weight_buffer_writer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_pkg.sv
// Purpose: shared constants, FSM encoding and types for the packed weight buffer writer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package weight_pkg;
    localparam int WEIGHT_W      = 7;                // bits per weight
    localparam int PACK          = 4;                // weights per RAM word
    localparam int DEPTH         = 256;              // RAM words per full load
    localparam int ADDR_W        = 8;                // clog2(DEPTH)
    localparam int WORD_W        = WEIGHT_W * PACK;  // 28-bit RAM word
    localparam int TOTAL_WEIGHTS = DEPTH * PACK;     // data beats per full load

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [WEIGHT_W-1:0] weight_t;
    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [ADDR_W-1:0]   addr_t;
endpackage

// File: rtl/weight_buffer_writer_if.sv
// Purpose: host-side stream plus RAM write port and status of the weight buffer writer.
// Latency: n/a (signal bundle).
// Backpressure: in_ready is driven by the writer; master drives start/in_*.
// Ports: start, in_valid/in_ready/in_weight/in_last (stream), wr_en/wr_addr/wr_data (RAM),
//        load_done/load_err (sticky status). master = host/bench, slave = writer.
interface weight_buffer_writer_if;
    import weight_pkg::*;

    logic    start;
    logic    in_valid;
    logic    in_ready;
    weight_t in_weight;
    logic    in_last;
    logic    wr_en;
    addr_t   wr_addr;
    word_t   wr_data;
    logic    load_done;
    logic    load_err;

    modport master (
        output start, in_valid, in_weight, in_last,
        input  in_ready, wr_en, wr_addr, wr_data, load_done, load_err
    );

    modport slave (
        input  start, in_valid, in_weight, in_last,
        output in_ready, wr_en, wr_addr, wr_data, load_done, load_err
    );
endinterface

// File: rtl/weight_packer.sv
// Purpose: shifts weights MSB-first into a word; flags the beat that completes 4 lanes.
// Latency: combinational word/valid on the completing beat (caller registers it).
// Backpressure: none; shifts on every i_beat, i_clr has priority.
// Ports: clk, rst_n, i_clr (restart lanes), i_beat/i_weight (accepted weight),
//        o_word_vld (4th lane this beat), o_word ({3 older lanes, i_weight}).
module weight_packer
    import weight_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_clr,
    input  logic    i_beat,
    input  weight_t i_weight,
    output logic    o_word_vld,
    output word_t   o_word
);
    // Only the three older lanes need storage; the 4th comes straight from the input.
    logic [WORD_W-WEIGHT_W-1:0] r_pack;
    logic [1:0]                 r_lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack <= '0;
            r_lane <= 2'd0;
        end else if (i_clr) begin
            r_pack <= '0;
            r_lane <= 2'd0;
        end else if (i_beat) begin
            r_pack <= {r_pack[WORD_W-2*WEIGHT_W-1:0], i_weight};
            r_lane <= r_lane + 2'd1;
        end
    end

    assign o_word_vld = i_beat && (r_lane == 2'd3);
    assign o_word     = {r_pack, i_weight};
endmodule

// File: rtl/weight_buffer_writer.sv
// Purpose: packs a 7-bit weight stream 4-per-word and writes 256 words to the weight RAM.
// Latency: wr_en one cycle after the 4th accepted beat of each word.
// Backpressure: in_ready high only while loading; every beat offered in LOAD is taken.
// Ports: clk, rst_n, bus (weight_buffer_writer_if.slave: stream in, RAM write, status).
// Option: define WEIGHT_CKSUM_EN to require a trailing checksum beat (sum of weights mod 128).
module weight_buffer_writer
    import weight_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    weight_buffer_writer_if.slave  bus
);
    state_t  r_state;
    logic    r_in_ready;
    logic    r_wr_en;
    addr_t   r_wr_addr;
    word_t   r_wr_data;
    logic    r_load_done;
    logic    r_load_err;
    addr_t   r_addr;
`ifdef WEIGHT_CKSUM_EN
    weight_t r_sum;
    logic    r_ck_phase;   // all data words written, waiting for the checksum beat
`endif

    logic    w_acc;
    logic    w_beat;
    logic    w_word_vld;
    logic    w_final;
    word_t   w_word;

    assign w_acc = bus.in_valid && r_in_ready;
    // start wins over a same-cycle beat, so that beat never reaches the packer.
`ifdef WEIGHT_CKSUM_EN
    assign w_beat = w_acc && !bus.start && !r_ck_phase;
`else
    assign w_beat = w_acc && !bus.start;
`endif
    assign w_final = w_word_vld && (r_addr == ADDR_W'(DEPTH - 1));

    weight_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (bus.start),
        .i_beat     (w_beat),
        .i_weight   (bus.in_weight),
        .o_word_vld (w_word_vld),
        .o_word     (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_addr      <= '0;
`ifdef WEIGHT_CKSUM_EN
            r_sum       <= '0;
            r_ck_phase  <= 1'b0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            if (bus.start) begin
                r_state     <= LOAD;
                r_in_ready  <= 1'b1;
                r_addr      <= '0;
                r_load_done <= 1'b0;
                r_load_err  <= 1'b0;
`ifdef WEIGHT_CKSUM_EN
                r_sum       <= '0;
                r_ck_phase  <= 1'b0;
`endif
            end else if (r_state == LOAD) begin
                // A completed word is always written, even when the same beat ends the load.
                if (w_word_vld) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_wr_data <= w_word;
                    if (!w_final) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                if (w_acc) begin
`ifdef WEIGHT_CKSUM_EN
                    if (r_ck_phase) begin
                        r_state    <= DONE;
                        r_in_ready <= 1'b0;
                        if (bus.in_last && (bus.in_weight == r_sum)) begin
                            r_load_done <= 1'b1;
                        end else begin
                            r_load_err  <= 1'b1;
                        end
                    end else begin
                        r_sum <= r_sum + bus.in_weight;
                        if (bus.in_last) begin
                            r_state    <= DONE;
                            r_in_ready <= 1'b0;
                            r_load_err <= 1'b1;
                        end else if (w_final) begin
                            r_ck_phase <= 1'b1;
                        end
                    end
`else
                    if (w_final) begin
                        r_state    <= DONE;
                        r_in_ready <= 1'b0;
                        if (bus.in_last) begin
                            r_load_done <= 1'b1;
                        end else begin
                            r_load_err  <= 1'b1;
                        end
                    end else if (bus.in_last) begin
                        r_state    <= DONE;
                        r_in_ready <= 1'b0;
                        r_load_err <= 1'b1;
                    end
`endif
                end
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.load_done = r_load_done;
    assign bus.load_err  = r_load_err;
endmodule

// File: tb/tb_weight_buffer_writer.sv
// Purpose: self-checking bench for weight_buffer_writer with a beat-count reference model.
// Latency: model expects wr_en the cycle after every 4th accepted beat.
// Backpressure: driver waits on in_ready (bounded) and inserts random valid gaps.
module tb_weight_buffer_writer;
    import weight_pkg::*;

`ifdef WEIGHT_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    weight_buffer_writer_if bus ();

    weight_buffer_writer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: counts accepted beats per load and derives every output from the count.
    logic        e_ready = 1'b0, e_wr_en = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [7:0]  e_addr  = '0;
    logic [27:0] e_data  = '0;
    int          m_cnt   = 0;
    logic [6:0]  m_sum   = '0;
    bit          m_ck    = 1'b0;
    logic [6:0]  m_w [0:TOTAL_WEIGHTS-1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ready = 1'b0; e_wr_en = 1'b0; e_done = 1'b0; e_err = 1'b0;
            e_addr  = '0;   e_data  = '0;
            m_cnt   = 0;    m_sum   = '0;   m_ck   = 1'b0;
        end else begin
            e_wr_en = 1'b0;
            if (bus.start) begin
                e_ready = 1'b1; e_done = 1'b0; e_err = 1'b0;
                m_cnt   = 0;    m_sum  = '0;   m_ck  = 1'b0;
            end else if (bus.in_valid && e_ready) begin
                if (m_ck) begin
                    e_ready = 1'b0;
                    if (bus.in_last && bus.in_weight == m_sum) e_done = 1'b1;
                    else                                       e_err  = 1'b1;
                end else begin
                    m_w[m_cnt] = bus.in_weight;
                    m_cnt      = m_cnt + 1;
                    m_sum      = m_sum + bus.in_weight;
                    if (m_cnt % PACK == 0) begin
                        e_wr_en = 1'b1;
                        e_addr  = 8'(m_cnt / PACK - 1);
                        e_data  = {m_w[m_cnt-4], m_w[m_cnt-3], m_w[m_cnt-2], m_w[m_cnt-1]};
                    end
                    if (CK) begin
                        if (bus.in_last) begin
                            e_ready = 1'b0; e_err = 1'b1;
                        end else if (m_cnt == TOTAL_WEIGHTS) begin
                            m_ck = 1'b1;
                        end
                    end else if (m_cnt == TOTAL_WEIGHTS) begin
                        e_ready = 1'b0;
                        if (bus.in_last) e_done = 1'b1;
                        else             e_err  = 1'b1;
                    end else if (bus.in_last) begin
                        e_ready = 1'b0; e_err = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle compare plus a RAM image of everything the DUT wrote.
    logic [27:0] ram [0:DEPTH-1];
    int          n_wr      = 0;
    int          last_addr = -1;

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", bus.in_ready, e_ready);
            check("wr_en", bus.wr_en, e_wr_en);
            check("load_done", bus.load_done, e_done);
            check("load_err", bus.load_err, e_err);
            if (e_wr_en) begin
                check("wr_addr", bus.wr_addr, e_addr);
                check("wr_data", bus.wr_data, e_data);
            end
            if (bus.wr_en) begin
                ram[bus.wr_addr] = bus.wr_data;
                n_wr++;
                last_addr = int'(bus.wr_addr);
            end
        end
    end

    logic [6:0] sw [0:TOTAL_WEIGHTS-1];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_beat(input logic [6:0] w, input logic l, input bit gaps);
        int   guard = 0;
        logic ok;
        if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        bus.in_valid  = 1'b1;
        bus.in_weight = w;
        bus.in_last   = l;
        do begin
            ok = bus.in_ready;
            tick();
            guard++;
        end while (!ok && guard < 2000);
        if (!ok) check("accept_timeout", ok, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run_stream(input int n, input int last_at, input bit rnd, input bit gaps,
                              input bit add_ck, input bit ck_bad, input bit do_start);
        logic [6:0] sum = '0;
        if (do_start) pulse_start();
        for (int i = 0; i < n; i++) begin
            sw[i] = rnd ? 7'($urandom) : 7'(i);
            sum   = sum + sw[i];
            send_beat(sw[i], i == last_at, gaps);
        end
        if (add_ck) send_beat(ck_bad ? sum + 7'd1 : sum, 1'b1, gaps);
        repeat (3) tick();
    endtask

    task automatic check_full(input int base);
        check("full_writes", n_wr - base, DEPTH);
        check("full_last_addr", last_addr, DEPTH - 1);
        check("full_done", bus.load_done, 1'b1);
        check("full_err", bus.load_err, 1'b0);
        check("full_ready_after", bus.in_ready, 1'b0);
        for (int a = 0; a < DEPTH; a++)
            check("ram_word", ram[a], {sw[4*a], sw[4*a+1], sw[4*a+2], sw[4*a+3]});
    endtask

    task automatic check_outputs_zero();
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_wr_en", bus.wr_en, 1'b0);
        check("rst_wr_addr", bus.wr_addr, 8'd0);
        check("rst_wr_data", bus.wr_data, 28'd0);
        check("rst_load_done", bus.load_done, 1'b0);
        check("rst_load_err", bus.load_err, 1'b0);
    endtask

    initial begin
        int base;
        int last_at;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_weight = '0; bus.in_last = 1'b0;

        // Reset state
        repeat (3) tick();
        check_outputs_zero();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;          // ignored while idle
        repeat (3) tick();
        check("idle_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;

        // Full ramp load, no gaps; first/last words pinned by hand
        base = n_wr;
        run_stream(TOTAL_WEIGHTS, CK ? -1 : TOTAL_WEIGHTS - 1, 1'b0, 1'b0, CK, 1'b0, 1'b1);
        check_full(base);
        check("word0_literal", ram[0], 28'h0004103);     // {0,1,2,3}
        check("word255_literal", ram[255], 28'hF9F7F7F); // {124,125,126,127}

        // Same stream with random valid gaps
        base = n_wr;
        run_stream(TOTAL_WEIGHTS, CK ? -1 : TOTAL_WEIGHTS - 1, 1'b0, 1'b1, CK, 1'b0, 1'b1);
        check_full(base);
        check("gap_word0_literal", ram[0], 28'h0004103);

        // Early in_last on beat 9: two words, partial discarded
        base = n_wr;
        run_stream(10, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        check("early_writes", n_wr - base, 2);
        check("early_last_addr", last_addr, 1);
        check("early_err", bus.load_err, 1'b1);
        check("early_done", bus.load_done, 1'b0);
        check("early_ready", bus.in_ready, 1'b0);

        // Restart after 50 beats; the beat offered with start is dropped
        run_stream(50, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_weight = 7'h55;
        base = n_wr;
        run_stream(TOTAL_WEIGHTS, CK ? -1 : TOTAL_WEIGHTS - 1, 1'b1, 1'b1, CK, 1'b0, 1'b1);
        check_full(base);

        // Reset mid-load right as a word write is pending
        pulse_start();
        for (int i = 0; i < 100; i++) send_beat(7'(i), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero();
        repeat (2) tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) tick();
        check("post_reset_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;

        // Missing in_last (or bad checksum): all words written, error flagged
        base = n_wr;
        run_stream(TOTAL_WEIGHTS, -1, 1'b0, 1'b0, CK, 1'b1, 1'b1);
        check("err_writes", n_wr - base, DEPTH);
        check("err_err", bus.load_err, 1'b1);
        check("err_done", bus.load_done, 1'b0);

        // Randomized loads: full with random data, or early last not on a word boundary
        for (int k = 0; k < 4; k++) begin
            base = n_wr;
            if (k % 2 == 0) begin
                run_stream(TOTAL_WEIGHTS, CK ? -1 : TOTAL_WEIGHTS - 1, 1'b1, 1'b1, CK, 1'b0, 1'b1);
                check_full(base);
            end else begin
                do last_at = $urandom_range(0, TOTAL_WEIGHTS - 2);
                while ((last_at + 1) % PACK == 0);
                run_stream(last_at + 1, last_at, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
                check("rand_early_writes", n_wr - base, (last_at + 1) / PACK);
                check("rand_early_err", bus.load_err, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
